// File: rtl/fp_mult_axis_collect.sv
// Collects products from a fixed-latency multiplier, buffers them in a small
// FIFO and streams them out on AXI4-Stream with packet framing. Upstream ready
// is credit-based: an issue is only accepted while buffered plus in-flight
// products leave room for it, so a product is never dropped.
module fp_mult_axis_collect #(
  parameter int data    = 32,
  parameter int LAT     = 3,
  parameter int DEPTH   = 8,
  parameter int PKT_LEN = 16
) (
  input  logic            axis_clk,
  input  logic            rst,
  input  logic            s_axis_valid,
  output logic            s_axis_ready,
  input  logic [data-1:0] mult_out,
  output logic [data-1:0] m_axis_data,
  output logic            m_axis_valid,
  output logic            m_axis_last,
  input  logic            m_axis_ready,
  output logic            overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + LAT + 1) + 1;
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [LAT-1:0]  dly;
  logic [data-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   used;
  logic [BW-1:0]   beat;
  logic            issue;
  logic            tap;
  logic            rd;
  logic            full;
  logic            wr_en;

  // Credit: buffered entries plus products still inside the multiplier.
  always_comb begin
    used = count;
    for (int i = 0; i < LAT; i++) begin
      used = used + CW'(dly[i]);
    end
  end

  // Ready comes only from registers; a read frees credit on the next cycle.
  assign s_axis_ready = (used < CW'(DEPTH));
  assign issue        = s_axis_valid & s_axis_ready;
  assign tap          = dly[LAT-1];
  assign m_axis_valid = (count != '0);
  assign rd           = m_axis_valid & m_axis_ready;
  assign full         = (count == CW'(DEPTH));
  // At full a write is only legal when the head leaves in the same cycle.
  assign wr_en        = tap & (~full | rd);
  assign m_axis_data  = m_axis_valid ? mem[rd_ptr] : '0;
  assign m_axis_last  = m_axis_valid & (beat == BW'(PKT_LEN - 1));

  // Delay line mirrors the multiplier pipeline: one bit per accepted issue.
  always_ff @(posedge axis_clk) begin
    if (rst) begin
      dly <= '0;
    end else begin
      dly[0] <= issue;
      for (int i = 1; i < LAT; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  // FIFO storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge axis_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= mult_out;
    end
  end

  // FIFO pointers, occupancy and sticky overflow on a dropped product.
  always_ff @(posedge axis_clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (tap & full & ~rd) begin
        overflow <= 1'b1;
      end
      case ({wr_en, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Beat counter for packet framing, advancing on each output handshake.
  always_ff @(posedge axis_clk) begin
    if (rst) begin
      beat <= '0;
    end else if (rd) begin
      beat <= (beat == BW'(PKT_LEN - 1)) ? '0 : beat + BW'(1);
    end
  end

endmodule

// File: tb/tb_fp_mult_axis_collect.sv
// Bench for fp_mult_axis_collect: a multiplier stand-in drives each product on
// mult_out just before its tap edge (random junk otherwise), and a reference
// model built from issue/consume bookkeeping predicts every output cycle.
module tb_fp_mult_axis_collect;
  localparam int LAT     = 3;
  localparam int DEPTH   = 8;
  localparam int PKT_LEN = 16;

  typedef struct { logic [31:0] v; int acc; } exp_t;
  typedef struct { logic [31:0] v; int due; } sch_t;

  logic        axis_clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_axis_valid = 1'b0;
  logic        s_axis_ready;
  logic [31:0] mult_out = '0;
  logic [31:0] m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_last;
  logic        m_axis_ready = 1'b0;
  logic        overflow;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          checking = 0;
  exp_t        exp_q[$];
  sch_t        sch_q[$];
  int          beat_m = 0;
  int          acc_total = 0;
  int          beats_out = 0;
  int          lasts_out = 0;
  logic [31:0] next_prod = '0;
  bit          auto_inc = 0;
  bit          rand_prod = 0;

  fp_mult_axis_collect #(.data(32), .LAT(LAT), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
    .axis_clk(axis_clk), .rst(rst),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .mult_out(mult_out),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
    .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
    .overflow(overflow)
  );

  always #5 axis_clk = ~axis_clk;
  always @(posedge axis_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge axis_clk);
    #1;
  endtask

  // Multiplier stand-in: product valid only in the cycle before its tap edge.
  always begin
    @(posedge axis_clk);
    #1;
    if (sch_q.size() > 0 && sch_q[0].due == cyc + 1) begin
      mult_out = sch_q[0].v;
      void'(sch_q.pop_front());
    end else begin
      mult_out = $urandom;
    end
  end

  // Reference check each cycle, then book the handshakes of the coming edge.
  always @(negedge axis_clk) begin
    bit exp_v;
    if (checking) begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].acc + LAT <= cyc);
      chk("ready", s_axis_ready, exp_q.size() < DEPTH);
      chk("valid", m_axis_valid, exp_v);
      chk("data", m_axis_data, exp_v ? exp_q[0].v : 32'h0);
      chk("last", m_axis_last, exp_v && (beat_m == PKT_LEN - 1));
      chk("overflow", overflow, 1'b0);
      if (rst) begin
        exp_q.delete();
        sch_q.delete();
        beat_m = 0;
      end else begin
        if (m_axis_valid && m_axis_ready && exp_v) begin
          void'(exp_q.pop_front());
          beat_m = (beat_m == PKT_LEN - 1) ? 0 : beat_m + 1;
          beats_out++;
          if (m_axis_last) lasts_out++;
        end
        if (s_axis_valid && s_axis_ready) begin
          exp_q.push_back('{v: next_prod, acc: cyc + 1});
          sch_q.push_back('{v: next_prod, due: cyc + 1 + LAT});
          acc_total++;
          if (auto_inc) next_prod = next_prod + 1;
          else if (rand_prod) next_prod = $urandom;
        end
      end
    end
  end

  task automatic drain();
    int guard;
    s_axis_valid = 1'b0;
    m_axis_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      tick();
      guard++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int a0, first, highs, b0, l0;
    tick();
    checking = 1;
    tick();
    rst = 1'b0;

    // Single issue: one valid cycle, LAT+1 cycles after the issue cycle.
    next_prod = 32'h40C00000;
    m_axis_ready = 1'b1;
    s_axis_valid = 1'b1;
    tick();
    s_axis_valid = 1'b0;
    first = 0;
    highs = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge axis_clk);
      if (m_axis_valid) begin
        highs++;
        if (first == 0) first = i;
        chk("t1_data", m_axis_data, 32'h40C00000);
      end
    end
    chk("t1_latency", first, LAT + 1);
    chk("t1_valid_cycles", highs, 1);
    tick();

    // Fill with the sink stalled: exactly DEPTH accepted.
    rand_prod = 1;
    next_prod = $urandom;
    m_axis_ready = 1'b0;
    a0 = acc_total;
    s_axis_valid = 1'b1;
    tick(20);
    chk("t2_accepts", acc_total - a0, DEPTH);
    chk("t2_ready_low", s_axis_ready, 1'b0);

    // One-beat drain frees exactly one credit.
    m_axis_ready = 1'b1;
    tick();
    m_axis_ready = 1'b0;
    tick(10);
    chk("t3_accepts", acc_total - a0, DEPTH + 1);
    drain();

    // 40 back-to-back issues with products 1..40 from a fresh beat count.
    pulse_rst();
    rand_prod = 0;
    auto_inc = 1;
    next_prod = 1;
    m_axis_ready = 1'b1;
    a0 = acc_total;
    b0 = beats_out;
    l0 = lasts_out;
    s_axis_valid = 1'b1;
    tick(40);
    s_axis_valid = 1'b0;
    chk("t4_accepts", acc_total - a0, 40);
    drain();
    chk("t4_beats", beats_out - b0, 40);
    chk("t4_lasts", lasts_out - l0, 2);
    chk("t4_end_beat", beat_m, 8);

    // Random valid/ready with phases that pin the FIFO at full and at empty.
    auto_inc = 0;
    rand_prod = 1;
    next_prod = $urandom;
    for (int ph = 0; ph < 12; ph++) begin
      for (int i = 0; i < 50; i++) begin
        s_axis_valid = ($urandom_range(0, 3) != 0);
        case (ph % 3)
          0:       m_axis_ready = ($urandom_range(0, 7) == 0);
          1:       m_axis_ready = ($urandom_range(0, 7) != 0);
          default: m_axis_ready = $urandom_range(0, 1);
        endcase
        tick();
      end
    end
    drain();

    // Reset with 5 buffered and 2 in flight; next packet framed from zero.
    m_axis_ready = 1'b0;
    s_axis_valid = 1'b1;
    tick(7);
    s_axis_valid = 1'b0;
    tick();
    chk("t6_buffered", m_axis_valid, 1'b1);
    pulse_rst();
    chk("t6_valid_after_rst", m_axis_valid, 1'b0);
    chk("t6_ready_after_rst", s_axis_ready, 1'b1);
    tick(LAT + 2);
    chk("t6_no_stale_write", m_axis_valid, 1'b0);
    auto_inc = 1;
    rand_prod = 0;
    next_prod = 32'h100;
    b0 = beats_out;
    l0 = lasts_out;
    m_axis_ready = 1'b1;
    s_axis_valid = 1'b1;
    tick(20);
    s_axis_valid = 1'b0;
    drain();
    chk("t6_beats", beats_out - b0, 20);
    chk("t6_lasts", lasts_out - l0, 1);

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
